// File: rtl/rv32i_pkg.sv
// Shared rv32i core definitions: datapath width, instruction size and the fetch sequencer states.
package rv32i_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    HOLD  = 3'd3,
    DRAIN = 3'd4
  } fetch_state_e;

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
    return addr & ~XLEN'(INSTR_BYTES - 1);
  endfunction

endpackage

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: one outstanding imem request, 3 cycles/instr at zero wait, holds word until decode ready.
// Define FETCH_CTRL_MISALIGN_TRAP_EN to reject misaligned redirects with a trap pulse instead of aligning them.
module fetch_ctrl
  import rv32i_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            misalign_trap
);

  fetch_state_e    state;
  logic [XLEN-1:0] pc;
  logic            rsp_owed;
  logic            parked;

  // A response is still owed after this edge: must pass through DRAIN so it never reaches decode.
  assign rsp_owed = (state == REQ && imem_req_ready) ||
                    ((state == WAIT || state == DRAIN) && !imem_rsp_valid);

  assign imem_req_valid = (state == REQ);
  assign imem_req_addr  = pc;
  assign instr_valid    = (state == HOLD);

`ifdef FETCH_CTRL_MISALIGN_TRAP_EN
  logic park;
  logic trap_q;
  logic misaligned;

  assign misaligned    = (redirect_pc[1:0] != 2'b00);
  assign parked        = park;
  assign misalign_trap = trap_q;
`else
  assign parked        = 1'b0;
  assign misalign_trap = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      instr    <= '0;
      instr_pc <= '0;
`ifdef FETCH_CTRL_MISALIGN_TRAP_EN
      park     <= 1'b0;
      trap_q   <= 1'b0;
`endif
    end else begin
`ifdef FETCH_CTRL_MISALIGN_TRAP_EN
      trap_q <= 1'b0;
`endif
      if (redirect_valid) begin
`ifdef FETCH_CTRL_MISALIGN_TRAP_EN
        if (misaligned) begin
          trap_q <= 1'b1;
          park   <= 1'b1;
          state  <= rsp_owed ? DRAIN : IDLE;
        end else begin
          pc    <= redirect_pc;
          park  <= 1'b0;
          state <= rsp_owed ? DRAIN : REQ;
        end
`else
        pc    <= align_pc(redirect_pc);
        state <= rsp_owed ? DRAIN : REQ;
`endif
      end else begin
        unique case (state)
          IDLE: begin
            if (!parked) state <= REQ;
          end
          REQ: begin
            if (imem_req_ready) state <= WAIT;
          end
          WAIT: begin
            if (imem_rsp_valid) begin
              instr    <= imem_rsp_data;
              instr_pc <= pc;
              state    <= HOLD;
            end
          end
          HOLD: begin
            if (instr_ready) begin
              pc    <= pc + XLEN'(INSTR_BYTES);
              state <= REQ;
            end
          end
          DRAIN: begin
            if (imem_rsp_valid) state <= parked ? IDLE : REQ;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios plus a randomized run against an architectural-PC reference model.
module tb_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        misalign_trap;

  logic        w_rst;
  logic        w_req_valid;
  logic        w_req_ready;
  logic [31:0] w_req_addr;
  logic        w_rsp_valid;
  logic [31:0] w_rsp_data;
  logic        w_instr_valid;
  logic        w_instr_ready;
  logic [31:0] w_instr;
  logic [31:0] w_instr_pc;
  logic        w_redirect_valid;
  logic [31:0] w_redirect_pc;
  logic        w_misalign_trap;

  int checks = 0;
  int errors = 0;

  // Reference model: architectural PC plus a single-slot memory with variable latency.
  logic [31:0] model_pc = 32'h0;
  bit          pending  = 1'b0;
  logic [31:0] paddr    = 32'h0;
  int          cnt      = 0;
  int          lat_fix  = 1;
  bit          mem_const = 1'b1;

  fetch_ctrl dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .misalign_trap(misalign_trap)
  );

  fetch_ctrl #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst(w_rst),
    .imem_req_valid(w_req_valid), .imem_req_ready(w_req_ready), .imem_req_addr(w_req_addr),
    .imem_rsp_valid(w_rsp_valid), .imem_rsp_data(w_rsp_data),
    .instr_valid(w_instr_valid), .instr_ready(w_instr_ready), .instr(w_instr), .instr_pc(w_instr_pc),
    .redirect_valid(w_redirect_valid), .redirect_pc(w_redirect_pc), .misalign_trap(w_misalign_trap)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] memfn(input logic [31:0] a);
    if (mem_const) return 32'h0000_0013;
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // Apply the inputs set for this cycle, update the model, and move to the next sampling point.
  task automatic tick();
    logic acc;
    logic cons;
    acc  = imem_req_valid && imem_req_ready;
    cons = instr_valid && instr_ready && !redirect_valid;
    if (rst) begin
      model_pc = 32'h0;
      pending  = 1'b0;
    end else begin
      if (redirect_valid) begin
`ifdef FETCH_CTRL_MISALIGN_TRAP_EN
        if (redirect_pc[1:0] == 2'b00) model_pc = redirect_pc;
`else
        model_pc = redirect_pc & 32'hFFFF_FFFC;
`endif
      end else if (cons) begin
        model_pc = model_pc + 32'd4;
      end
      if (imem_rsp_valid) pending = 1'b0;
      if (acc) begin
        pending = 1'b1;
        paddr   = imem_req_addr;
        cnt     = (lat_fix != 0) ? lat_fix : $urandom_range(1, 3);
      end
    end
    @(posedge clk);
    @(negedge clk);
    if (pending && cnt > 0) cnt--;
    imem_rsp_valid = pending && (cnt == 0);
    imem_rsp_data  = pending ? memfn(paddr) : $urandom;
  endtask

  task automatic test_wrap();
    w_rst = 1'b0;
    @(negedge clk);
    checks++; if (w_req_valid !== 1'b1) begin errors++; $display("FAIL wrap_first_req: got %b want 1", w_req_valid); end
    checks++; if (w_req_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_first_addr: got %h want fffffffc", w_req_addr); end
    w_req_ready = 1'b1;
    @(negedge clk);
    w_req_ready = 1'b0;
    w_rsp_valid = 1'b1;
    w_rsp_data  = 32'h0000_0013;
    @(negedge clk);
    w_rsp_valid = 1'b0;
    checks++; if (w_instr_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_instr_pc: got %h want fffffffc", w_instr_pc); end
    w_instr_ready = 1'b1;
    @(negedge clk);
    w_instr_ready = 1'b0;
    checks++; if (w_req_valid !== 1'b1) begin errors++; $display("FAIL wrap_second_req: got %b want 1", w_req_valid); end
    checks++; if (w_req_addr !== 32'h0) begin errors++; $display("FAIL wrap_second_addr: got %h want 00000000", w_req_addr); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b want 0", imem_req_valid); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_instr_valid: got %b want 0", instr_valid); end
    checks++; if (instr !== 32'h0 || instr_pc !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h/%h want 0/0", instr, instr_pc); end
    checks++; if (misalign_trap !== 1'b0) begin errors++; $display("FAIL reset_trap: got %b want 0", misalign_trap); end
    checks++; if (imem_req_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", imem_req_addr); end
    rst = 1'b0;
    tick();
    checks++; if (imem_req_valid !== 1'b1) begin errors++; $display("FAIL first_req_valid: got %b want 1", imem_req_valid); end
    checks++; if (imem_req_addr !== 32'h0) begin errors++; $display("FAIL first_req_addr: got %h want 0", imem_req_addr); end
  endtask

  task automatic test_stream();
    mem_const = 1'b1;
    lat_fix = 1;
    imem_req_ready = 1'b1;
    instr_ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      checks++; if (instr_valid !== (k % 3 == 2)) begin errors++; $display("FAIL stream_valid[%0d]: got %b want %b", k, instr_valid, (k % 3 == 2)); end
      checks++; if (imem_req_valid !== (k % 3 == 0)) begin errors++; $display("FAIL stream_req[%0d]: got %b want %b", k, imem_req_valid, (k % 3 == 0)); end
      if (k % 3 == 0) begin
        checks++; if (imem_req_addr !== 32'(k / 3 * 4)) begin errors++; $display("FAIL stream_addr[%0d]: got %h want %h", k, imem_req_addr, 32'(k / 3 * 4)); end
      end
      if (k % 3 == 2) begin
        checks++; if (instr_pc !== 32'(k / 3 * 4)) begin errors++; $display("FAIL stream_pc[%0d]: got %h want %h", k, instr_pc, 32'(k / 3 * 4)); end
        checks++; if (instr !== 32'h13) begin errors++; $display("FAIL stream_instr[%0d]: got %h want 00000013", k, instr); end
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] hi;
    logic [31:0] hp;
    int n;
    mem_const = 1'b0;
    lat_fix = 0;
    instr_ready = 1'b0;
    imem_req_ready = 1'b1;
    n = 0;
    while (!instr_valid && n < 20) begin tick(); n++; end
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL bp_reach_hold: got %b want 1 within 20 cycles", instr_valid); end
    hi = instr;
    hp = instr_pc;
    checks++; if (hp !== 32'hC) begin errors++; $display("FAIL bp_pc: got %h want 0000000c", hp); end
    checks++; if (hi !== memfn(32'hC)) begin errors++; $display("FAIL bp_instr: got %h want %h", hi, memfn(32'hC)); end
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++; if (instr_valid !== 1'b1 || instr !== hi || instr_pc !== hp) begin errors++; $display("FAIL bp_stable[%0d]: got %b %h %h want 1 %h %h", k, instr_valid, instr, instr_pc, hi, hp); end
      checks++; if (imem_req_valid !== 1'b0 || imem_req_addr !== hp) begin errors++; $display("FAIL bp_no_req[%0d]: got %b %h want 0 %h", k, imem_req_valid, imem_req_addr, hp); end
    end
    instr_ready = 1'b1;
    imem_req_ready = 1'b0;
    tick();
    instr_ready = 1'b0;
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== hp + 32'd4) begin errors++; $display("FAIL bp_next_req: got %b %h want 1 %h", imem_req_valid, imem_req_addr, hp + 32'd4); end
  endtask

  task automatic test_redirect_wait();
    int n;
    imem_req_ready = 1'b1;
    lat_fix = 3;
    tick();
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    tick();
    redirect_valid = 1'b0;
    n = 0;
    while (!imem_req_valid && n < 10) begin
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rw_no_instr[%0d]: got %b want 0", n, instr_valid); end
      tick();
      n++;
    end
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin errors++; $display("FAIL rw_next_req: got %b %h want 1 00000100", imem_req_valid, imem_req_addr); end
    lat_fix = 1;
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    tick();
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h100) begin errors++; $display("FAIL rw_instr_pc: got %b %h want 1 00000100", instr_valid, instr_pc); end
    checks++; if (instr !== memfn(32'h100)) begin errors++; $display("FAIL rw_instr: got %h want %h", instr, memfn(32'h100)); end
  endtask

  task automatic test_redirect_hold();
    instr_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    tick();
    redirect_valid = 1'b0;
    instr_ready = 1'b0;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rh_drop: got %b want 0", instr_valid); end
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200) begin errors++; $display("FAIL rh_next_req: got %b %h want 1 00000200", imem_req_valid, imem_req_addr); end
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    tick();
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h200) begin errors++; $display("FAIL rh_instr_pc: got %b %h want 1 00000200", instr_valid, instr_pc); end
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
  endtask

  task automatic test_misalign();
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h102;
    tick();
    redirect_valid = 1'b0;
`ifdef FETCH_CTRL_MISALIGN_TRAP_EN
    checks++; if (misalign_trap !== 1'b1) begin errors++; $display("FAIL ma_trap: got %b want 1", misalign_trap); end
    tick();
    checks++; if (misalign_trap !== 1'b0) begin errors++; $display("FAIL ma_trap_pulse: got %b want 0", misalign_trap); end
    imem_req_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      checks++; if (imem_req_valid !== 1'b0 || imem_req_addr !== 32'h204) begin errors++; $display("FAIL ma_parked[%0d]: got %b %h want 0 00000204", k, imem_req_valid, imem_req_addr); end
      tick();
    end
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h300;
    tick();
    redirect_valid = 1'b0;
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h300) begin errors++; $display("FAIL ma_recover: got %b %h want 1 00000300", imem_req_valid, imem_req_addr); end
`else
    checks++; if (misalign_trap !== 1'b0) begin errors++; $display("FAIL ma_trap_off: got %b want 0", misalign_trap); end
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin errors++; $display("FAIL ma_aligned_req: got %b %h want 1 00000100", imem_req_valid, imem_req_addr); end
`endif
  endtask

  task automatic test_random();
    int delivered;
    delivered = 0;
    mem_const = 1'b0;
    lat_fix = 0;
    for (int c = 0; c < 1500; c++) begin
      imem_req_ready = ($urandom_range(0, 9) < 7);
      instr_ready    = ($urandom_range(0, 9) < 6);
      redirect_valid = ($urandom_range(0, 19) == 0);
`ifdef FETCH_CTRL_MISALIGN_TRAP_EN
      redirect_pc    = $urandom & 32'hFFFF_FFFC;
`else
      redirect_pc    = $urandom;
`endif
      if (imem_req_valid) begin
        checks++; if (pending) begin errors++; $display("FAIL rnd_one_outstanding[%0d]: got req with response owed", c); end
        checks++; if (imem_req_addr !== model_pc) begin errors++; $display("FAIL rnd_addr[%0d]: got %h want %h", c, imem_req_addr, model_pc); end
      end
      if (instr_valid) begin
        checks++; if (instr_pc !== model_pc) begin errors++; $display("FAIL rnd_instr_pc[%0d]: got %h want %h", c, instr_pc, model_pc); end
        checks++; if (instr !== memfn(model_pc)) begin errors++; $display("FAIL rnd_instr[%0d]: got %h want %h", c, instr, memfn(model_pc)); end
        if (instr_ready && !redirect_valid) delivered++;
      end
      checks++; if (misalign_trap !== 1'b0) begin errors++; $display("FAIL rnd_trap[%0d]: got %b want 0", c, misalign_trap); end
      tick();
    end
    redirect_valid = 1'b0;
    checks++; if (delivered < 100) begin errors++; $display("FAIL rnd_progress: got %0d deliveries want >= 100", delivered); end
  endtask

  initial begin
    rst = 1'b1;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data = 32'h0;
    instr_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    w_rst = 1'b1;
    w_req_ready = 1'b0;
    w_rsp_valid = 1'b0;
    w_rsp_data = 32'h0;
    w_instr_ready = 1'b0;
    w_redirect_valid = 1'b0;
    w_redirect_pc = 32'h0;
    @(negedge clk);
    @(negedge clk);
    test_wrap();
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_wait();
    test_redirect_hold();
    test_misalign();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete within time limit");
    $fatal(1, "timeout");
  end

endmodule
